// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the ALU arbiter and the shared ALU.
package alu_pkg;
  localparam int unsigned ALU_OP_W   = 3;
  localparam int unsigned ALU_DATA_W = 32;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4
  } alu_op_t;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;

  function automatic logic op_illegal(input logic [ALU_OP_W-1:0] op);
    return op > ALU_XOR;
  endfunction
endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-facing request/response channels of the ALU arbiter.
// rsp_err exists only when ALU_ARB_ERR_EN is defined.
interface alu_arbiter_if
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = ALU_DATA_W,
  parameter int unsigned OP_W    = ALU_OP_W
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*OP_W-1:0]   req_op;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]         rsp_data;
`ifdef ALU_ARB_ERR_EN
  logic                      rsp_err;

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );
`else
  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );
`endif
endinterface

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   index,
  output logic               any
);
  logic        found;
  int unsigned pos;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    pos   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = (32'(ptr) + k) % NUM_REQ;
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        index      = PTR_W'(pos);
      end
    end
  end

  assign any = |req;
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end sharing one combinational ALU among NUM_REQ requesters.
// Define ALU_ARB_ERR_EN to flag illegal opcodes on rsp_err with a zero result.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = ALU_DATA_W,
  parameter int unsigned OP_W    = ALU_OP_W
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus,
  output logic [31:0]  alu_control,
  output logic [31:0]  operand1,
  output logic [31:0]  operand2,
  input  logic [31:0]  alu_result
);
  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t         state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr, grant_q, grant_idx, ptr_next;
  logic [NUM_REQ-1:0] grant, req_ready, rsp_valid;
  logic               req_any;
  logic [OP_W-1:0]    op_q, op_sel;
  logic [DATA_W-1:0]  a_q, b_q, res_q, a_sel, b_sel, res_d;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .index (grant_idx),
    .any   (req_any)
  );

  assign op_sel   = bus.req_op[grant_idx*OP_W +: OP_W];
  assign a_sel    = bus.req_a[grant_idx*DATA_W +: DATA_W];
  assign b_sel    = bus.req_b[grant_idx*DATA_W +: DATA_W];
  assign ptr_next = (32'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + 1'b1;

  // rst_n gates req_ready so no grant is advertised while reset is held
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    rsp_valid = '0;
    unique case (state_q)
      IDLE: if (req_any && rst_n) begin
        req_ready = grant;
        state_d   = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: begin
        rsp_valid[grant_q] = 1'b1;
        if (bus.rsp_ready[grant_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_ptr  <= '0;
      grant_q <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_any) begin
        grant_q <= grant_idx;
        op_q    <= op_sel;
        a_q     <= a_sel;
        b_q     <= b_sel;
      end
      if (state_q == EXEC) res_q <= res_d;
      if (state_q == RESP && bus.rsp_ready[grant_q]) rr_ptr <= ptr_next;
    end
  end

`ifdef ALU_ARB_ERR_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          err_q <= 1'b0;
    else if (state_q == IDLE && req_any) err_q <= op_illegal(op_sel);
  end

  assign res_d       = err_q ? '0 : alu_result;
  assign bus.rsp_err = (state_q == RESP) && err_q;
`else
  assign res_d = alu_result;
`endif

  assign alu_control   = {{(32-OP_W){1'b0}}, op_q};
  assign operand1      = a_q;
  assign operand2      = b_q;
  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = res_q;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_hold
    a_valid_hold: assert property (@(posedge clk) disable iff (!rst_n)
      bus.req_valid[i] && !bus.req_ready[i] |=> bus.req_valid[i]);
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: transaction-level model of arbitration,
// latency and results, driven by directed steps and $urandom traffic.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int N = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] alu_control, operand1, operand2, alu_result;

  alu_arbiter_if #(.NUM_REQ(N), .DATA_W(32), .OP_W(3)) bus ();

  alu_arbiter #(.NUM_REQ(N), .DATA_W(32), .OP_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .alu_control (alu_control),
    .operand1    (operand1),
    .operand2    (operand2),
    .alu_result  (alu_result)
  );

  always #5 clk = ~clk;

  // stand-in for the shared ALU
  always_comb begin
    alu_result = '0;
    if (alu_control[31:3] == '0) begin
      case (alu_op_t'(alu_control[2:0]))
        ALU_ADD: alu_result = operand1 + operand2;
        ALU_SUB: alu_result = operand1 - operand2;
        ALU_AND: alu_result = operand1 & operand2;
        ALU_OR:  alu_result = operand1 | operand2;
        ALU_XOR: alu_result = operand1 ^ operand2;
        default: alu_result = '0;
      endcase
    end
  end

  int checks = 0, failures = 0;

  // model state
  bit          pend_v[N];
  logic [2:0]  pend_op[N];
  logic [31:0] pend_a[N], pend_b[N];
  int          grants[N];
  int          infl = -1, phase = 0, ptr = 0, stall_left = 0, stall_mode = 0;
  int          done_cnt = 0;
  logic [2:0]  cur_op;
  logic [31:0] cur_a, cur_b, cur_res, last_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int j;
      j = (ptr + k) % N;
      if (pend_v[j]) return j;
    end
    return -1;
  endfunction

  task automatic new_req(input int i);
    pend_v[i]  = 1'b1;
    pend_op[i] = 3'($urandom_range(0, 7));
    pend_a[i]  = $urandom;
    pend_b[i]  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'(0));
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
    chk({tag, "_rsp_data"},  64'(bus.rsp_data),  64'(0));
    chk({tag, "_alu_ctl"},   64'(alu_control),   64'(0));
    chk({tag, "_op1"},       64'(operand1),      64'(0));
    chk({tag, "_op2"},       64'(operand2),      64'(0));
`ifdef ALU_ARB_ERR_EN
    chk({tag, "_rsp_err"},   64'(bus.rsp_err),   64'(0));
`endif
  endtask

  // one clock: drive at negedge, compare 1 time unit later, advance the model
  task automatic step();
    logic [N-1:0] rr, exp_ready, exp_rv;
    int g;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]       = pend_v[i];
      bus.req_op[i*3 +: 3]   = pend_op[i];
      bus.req_a[i*32 +: 32]  = pend_a[i];
      bus.req_b[i*32 +: 32]  = pend_b[i];
    end
    rr = N'($urandom);
    if (infl >= 0 && phase == 2) rr[infl] = (stall_left == 0);
    bus.rsp_ready = rr;
    #1;
    exp_ready = '0;
    exp_rv    = '0;
    g         = -1;
    if (infl < 0) begin
      g = pick();
      if (g >= 0) exp_ready[g] = 1'b1;
    end else if (phase == 2) begin
      exp_rv[infl] = 1'b1;
    end
    chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rv));
    if (infl >= 0 && phase == 1) begin
      chk("alu_control", 64'(alu_control), 64'({29'd0, cur_op}));
      chk("operand1",    64'(operand1),    64'(cur_a));
      chk("operand2",    64'(operand2),    64'(cur_b));
    end
    if (infl >= 0 && phase == 2) chk("rsp_data", 64'(bus.rsp_data), 64'(cur_res));
`ifdef ALU_ARB_ERR_EN
    chk("rsp_err", 64'(bus.rsp_err), 64'(infl >= 0 && phase == 2 && cur_op > 3'd4));
`endif
    if (infl < 0) begin
      if (g >= 0) begin
        infl      = g;
        phase     = 1;
        cur_op    = pend_op[g];
        cur_a     = pend_a[g];
        cur_b     = pend_b[g];
        cur_res   = model_result(cur_op, cur_a, cur_b);
        pend_v[g] = 1'b0;
        grants[g]++;
      end
    end else if (phase == 1) begin
      phase      = 2;
      stall_left = (stall_mode < 0) ? $urandom_range(0, 3) : stall_mode;
    end else if (rr[infl]) begin
      last_data = bus.rsp_data;
      done_cnt++;
      ptr   = (infl + 1) % N;
      infl  = -1;
      phase = 0;
    end else begin
      stall_left--;
    end
  endtask

  task automatic directed(input string tag, input int i, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int start, n;
    start      = done_cnt;
    n          = 0;
    pend_v[i]  = 1'b1;
    pend_op[i] = op;
    pend_a[i]  = a;
    pend_b[i]  = b;
    while (done_cnt == start && n < 12) begin
      step();
      n++;
    end
    chk({tag, "_data"},    64'(last_data), 64'(exp));
    chk({tag, "_latency"}, 64'(n),         64'(3));
  endtask

  task automatic drain(input string tag);
    int n;
    bit busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < 200) begin
      busy = (infl >= 0);
      for (int i = 0; i < N; i++) if (pend_v[i]) busy = 1'b1;
      if (busy) begin
        step();
        n++;
      end
    end
    chk({tag, "_drained"}, 64'(busy), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, total;
    for (int i = 0; i < N; i++) begin
      pend_v[i] = 1'b0; pend_op[i] = '0; pend_a[i] = '0; pend_b[i] = '0; grants[i] = 0;
    end
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = '0;

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    stall_mode = 0;
    directed("add",  0, 3'd0, 32'd5,          32'd7,          32'd12);
    directed("sub",  1, 3'd1, 32'd0,          32'd1,          32'hFFFF_FFFF);
    directed("and",  2, 3'd2, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'h00F0_00F0);
    directed("or",   3, 3'd3, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'hFFF0_FFF0);
    directed("xor",  0, 3'd4, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'hFF00_FF00);
    directed("ill6", 1, 3'd6, 32'h1234_5678,  32'h0000_0001,  32'd0);

    // all requesters continuously valid: one grant every 3 cycles, each gets a turn
    for (int i = 0; i < N; i++) grants[i] = 0;
    n = 0;
    total = 0;
    while (total < 12 && n < 60) begin
      for (int i = 0; i < N; i++) if (!pend_v[i]) new_req(i);
      step();
      n++;
      total = grants[0] + grants[1] + grants[2] + grants[3];
    end
    chk("rr_cycles", 64'(n), 64'(34));
    for (int i = 0; i < N; i++) chk($sformatf("rr_grants%0d", i), 64'(grants[i]), 64'(3));
    drain("rr");

    // requester 1 held in RESP for 5 cycles while others queue up
    stall_mode = 5;
    pend_v[1] = 1'b0;
    new_req(1);
    n = 0;
    step();
    new_req(0);
    new_req(2);
    new_req(3);
    while (done_cnt == 0 || infl >= 0) begin
      if (infl < 0 || n >= 20) break;
      step();
      n++;
    end
    chk("bp_cycles", 64'(n), 64'(7));
    stall_mode = 0;
    drain("bp");

    stall_mode = -1;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) if (!pend_v[i] && $urandom_range(0, 2) == 0) new_req(i);
      step();
    end
    stall_mode = 0;
    drain("rand");

    // asynchronous reset while a transaction sits in EXEC
    pend_v[2] = 1'b0;
    new_req(2);
    step();
    chk("pre_rst_phase", 64'(phase), 64'(1));
    @(negedge clk);
    bus.req_valid = '1;
    bus.rsp_ready = '1;
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("rst_exec");
    infl = -1;
    phase = 0;
    ptr = 0;
    for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = '0;
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) new_req(i);
    step();
    chk("rst_first_grant", 64'(infl), 64'(0));
    drain("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
